// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: segment shift register on the cell grid, move/collision/apple
// handling and a registered per-cell classification port for the pixel engine.
module snake_game_ctrl #(
    parameter int MAX_LEN = 16,
    parameter int START_X = 20,
    parameter int START_Y = 15,
    parameter int GRID_W  = 40,
    parameter int GRID_H  = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       move_tick,
    input  logic       dir_valid,
    input  logic [1:0] dir_in,
    input  logic [5:0] apple_x,
    input  logic [4:0] apple_y,
    input  logic [5:0] query_x,
    input  logic [4:0] query_y,
    output logic [1:0] snake_type,
    output logic       apple_eaten,
    output logic       game_over,
    output logic [4:0] length,
    output logic [7:0] score
);

    // state | meaning
    // IDLE  | initial snake shown, waiting for start
    // PLAY  | snake advances on move_tick
    // DEAD  | collision happened, snake frozen, waiting for start
    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_DEAD} state_t;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    localparam logic [1:0] CELL_NONE = 2'b00;
    localparam logic [1:0] CELL_HEAD = 2'b01;
    localparam logic [1:0] CELL_BODY = 2'b10;
    localparam logic [1:0] CELL_WALL = 2'b11;

    state_t     state_q;
    logic [5:0] seg_x_q [MAX_LEN];
    logic [4:0] seg_y_q [MAX_LEN];
    logic [1:0] dir_q;
    logic [1:0] moved_dir_q;
    logic [4:0] length_q;
    logic [7:0] score_q;
    logic [1:0] snake_type_q;
    logic       apple_eaten_q;
    logic       game_over_q;

    logic [5:0] head_x_d;
    logic [4:0] head_y_d;
    logic       wall_hit;
    logic       self_hit;
    logic       apple_hit;
    logic       do_move;
    logic       load_init;
    logic [1:0] moved_dir_d;
    logic       dir_accept;
    logic [1:0] type_d;

    always_comb begin
        head_x_d = seg_x_q[0];
        head_y_d = seg_y_q[0];
        case (dir_q)
            DIR_UP:    head_y_d = seg_y_q[0] - 5'd1;
            DIR_LEFT:  head_x_d = seg_x_q[0] - 6'd1;
            DIR_RIGHT: head_x_d = seg_x_q[0] + 6'd1;
            DIR_DOWN:  head_y_d = seg_y_q[0] + 5'd1;
        endcase

        wall_hit = (head_x_d == 6'd0) || (head_x_d == 6'(GRID_W - 1)) ||
                   (head_y_d == 5'd0) || (head_y_d == 5'(GRID_H - 1));

        // The tail cell vacates on this move, so only seg1..length-2 can be hit.
        self_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (({1'b0, length_q} >= 6'(i) + 6'd2) &&
                (seg_x_q[i] == head_x_d) && (seg_y_q[i] == head_y_d))
                self_hit = 1'b1;
        end

        apple_hit  = (head_x_d == apple_x) && (head_y_d == apple_y);
        do_move    = (state_q == ST_PLAY) && move_tick && !wall_hit && !self_hit;
        load_init  = (state_q == ST_DEAD) && start;

        // Reversal check is against the direction the snake will have moved in after this edge.
        moved_dir_d = do_move ? dir_q : moved_dir_q;
        dir_accept  = dir_valid && (dir_in != ~moved_dir_d);
    end

    always_comb begin
        type_d = CELL_NONE;
        if ((query_x == 6'd0) || (query_x == 6'(GRID_W - 1)) ||
            (query_y == 5'd0) || (query_y == 5'(GRID_H - 1))) begin
            type_d = CELL_WALL;
        end else if ((query_x == seg_x_q[0]) && (query_y == seg_y_q[0])) begin
            type_d = CELL_HEAD;
        end else begin
            for (int i = 1; i < MAX_LEN; i++) begin
                if ((5'(i) < length_q) && (seg_x_q[i] == query_x) && (seg_y_q[i] == query_y))
                    type_d = CELL_BODY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || load_init) begin
            state_q <= reset ? ST_PLAY : ST_IDLE;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= (i < 3) ? 6'(START_X - i) : 6'd0;
                seg_y_q[i] <= (i < 3) ? 5'(START_Y) : 5'd0;
            end
            dir_q         <= DIR_RIGHT;
            moved_dir_q   <= DIR_RIGHT;
            length_q      <= 5'd3;
            score_q       <= 8'd0;
            apple_eaten_q <= 1'b0;
            game_over_q   <= 1'b0;
            snake_type_q  <= reset ? type_d : CELL_NONE;
        end else begin
            snake_type_q  <= type_d;
            apple_eaten_q <= 1'b0;
            moved_dir_q   <= moved_dir_d;
            if (dir_accept)
                dir_q <= dir_in;
            case (state_q)
                ST_IDLE: begin
                    if (start)
                        state_q <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (move_tick) begin
                        if (wall_hit || self_hit) begin
                            state_q     <= ST_DEAD;
                            game_over_q <= 1'b1;
                        end else begin
                            for (int i = MAX_LEN - 1; i > 0; i--) begin
                                seg_x_q[i] <= seg_x_q[i-1];
                                seg_y_q[i] <= seg_y_q[i-1];
                            end
                            seg_x_q[0] <= head_x_d;
                            seg_y_q[0] <= head_y_d;
                            if (apple_hit) begin
                                apple_eaten_q <= 1'b1;
                                if (length_q != 5'(MAX_LEN))
                                    length_q <= length_q + 5'd1;
                                if (score_q != 8'hFF)
                                    score_q <= score_q + 8'd1;
                            end
                        end
                    end
                end
                ST_DEAD: begin
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign snake_type  = snake_type_q;
    assign apple_eaten = apple_eaten_q;
    assign game_over   = game_over_q;
    assign length      = length_q;
    assign score       = score_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: directed scenarios plus random play checked every cycle
// against a queue-based model of the snake.
module tb_snake_game_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, move_tick, dir_valid;
    logic [1:0] dir_in;
    logic [5:0] apple_x, query_x;
    logic [4:0] apple_y, query_y;
    logic [1:0] snake_type;
    logic       apple_eaten, game_over;
    logic [4:0] length;
    logic [7:0] score;

    always #5 clk = ~clk;

    snake_game_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .move_tick(move_tick),
        .dir_valid(dir_valid), .dir_in(dir_in), .apple_x(apple_x), .apple_y(apple_y),
        .query_x(query_x), .query_y(query_y), .snake_type(snake_type),
        .apple_eaten(apple_eaten), .game_over(game_over), .length(length), .score(score)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Model: snake as a queue of cells, head at the front; queue size is the length.
    int mx[$], my[$];
    int mstate;   // 0 idle, 1 play, 2 dead
    int mdir, mmoved, mscore, mtype;
    int meaten;

    function automatic void m_init(input int st);
        mx = '{20, 19, 18};
        my = '{15, 15, 15};
        mdir = 2; mmoved = 2; mscore = 0; mstate = st; meaten = 0;
    endfunction

    function automatic int m_classify(input int qx, input int qy);
        if (qx == 0 || qx == 39 || qy == 0 || qy == 29) return 3;
        if (qx == mx[0] && qy == my[0]) return 1;
        for (int i = 1; i < mx.size(); i++)
            if (qx == mx[i] && qy == my[i]) return 2;
        return 0;
    endfunction

    function automatic void m_edge(input int r, input int st, input int tk, input int dv,
                                   input int din, input int ax, input int ay,
                                   input int qx, input int qy);
        int hx, hy, nm;
        bit hit;
        if (r == 0) begin
            m_init(0);
            mtype = 0;
            return;
        end
        mtype = m_classify(qx, qy);
        meaten = 0;
        if (mstate == 2 && st != 0) begin
            m_init(1);
            return;
        end
        nm = mmoved;
        if (mstate == 0) begin
            if (st != 0) mstate = 1;
        end else if (mstate == 1 && tk != 0) begin
            hx = mx[0]; hy = my[0];
            if (mdir == 0) hy = hy - 1;
            else if (mdir == 1) hx = hx - 1;
            else if (mdir == 2) hx = hx + 1;
            else hy = hy + 1;
            hit = (hx == 0 || hx == 39 || hy == 0 || hy == 29);
            for (int i = 1; i <= mx.size() - 2; i++)
                if (hx == mx[i] && hy == my[i]) hit = 1;
            if (hit) begin
                mstate = 2;
            end else begin
                mx.push_front(hx); my.push_front(hy);
                nm = mdir;
                if (hx == ax && hy == ay) begin
                    meaten = 1;
                    if (mscore < 255) mscore++;
                    if (mx.size() > 16) begin void'(mx.pop_back()); void'(my.pop_back()); end
                end else begin
                    void'(mx.pop_back()); void'(my.pop_back());
                end
            end
        end
        mmoved = nm;
        if (dv != 0 && din != 3 - nm) mdir = din;
    endfunction

    task automatic step(input int r, input int st, input int tk, input int dv, input int din,
                        input int ax, input int ay, input int qx, input int qy);
        reset = (r != 0); start = (st != 0); move_tick = (tk != 0); dir_valid = (dv != 0);
        dir_in = 2'(din); apple_x = 6'(ax); apple_y = 5'(ay); query_x = 6'(qx); query_y = 5'(qy);
        @(posedge clk);
        m_edge(r, st, tk, dv, din, ax, ay, qx, qy);
        #1;
        check("snake_type", snake_type, mtype);
        check("apple_eaten", apple_eaten, meaten);
        check("game_over", game_over, (mstate == 2));
        check("length", length, mx.size());
        check("score", score, mscore);
    endtask

    task automatic idle(input int qx, input int qy);
        step(1, 0, 0, 0, 0, 0, 0, qx, qy);
    endtask
    task automatic tick(input int ax, input int ay);
        step(1, 0, 1, 0, 0, ax, ay, 10, 10);
    endtask
    task automatic setdir(input int d);
        step(1, 0, 0, 1, d, 0, 0, 10, 10);
    endtask
    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 20, 15);
        step(0, 0, 0, 0, 0, 0, 0, 20, 15);
        check("rst_type", snake_type, 0);
    endtask
    task automatic go();
        step(1, 1, 0, 0, 0, 0, 0, 10, 10);
    endtask

    initial begin
        int ax, ay, qx, qy, k;
        // Reset state and query classification
        do_reset();
        idle(20, 15); check("q_head", snake_type, 1);
        idle(19, 15); check("q_body", snake_type, 2);
        idle(17, 15); check("q_none", snake_type, 0);
        idle(0, 5);   check("q_wall", snake_type, 3);
        check("rst_len", length, 3); check("rst_score", score, 0); check("rst_over", game_over, 0);

        // Three plain moves
        go();
        repeat (3) begin tick(0, 0); idle(10, 10); end
        idle(23, 15); check("mv_head", snake_type, 1);
        idle(22, 15); check("mv_b1", snake_type, 2);
        idle(21, 15); check("mv_b2", snake_type, 2);
        idle(20, 15); check("mv_old", snake_type, 0);

        // Apple growth
        do_reset();
        step(1, 1, 0, 0, 0, 21, 15, 10, 10);
        tick(21, 15);
        check("ap_eaten", apple_eaten, 1); check("ap_len", length, 4); check("ap_score", score, 1);
        idle(18, 15);
        check("ap_pulse", apple_eaten, 0); check("ap_tail", snake_type, 2);

        // Reversal drop and coincident direction change
        do_reset(); go();
        setdir(1);
        tick(0, 0); idle(21, 15); check("rev_head", snake_type, 1);
        step(1, 0, 1, 1, 0, 0, 0, 10, 10);
        idle(22, 15); check("co_head", snake_type, 1);
        tick(0, 0); idle(22, 14); check("up_head", snake_type, 1);

        // Wall death, freeze, restart
        do_reset(); go(); setdir(0);
        repeat (14) tick(0, 0);
        check("w_alive", game_over, 0);
        tick(0, 0); check("w_over", game_over, 1);
        tick(0, 0); idle(20, 1);
        check("w_frozen", snake_type, 1); check("w_over2", game_over, 1);
        step(1, 1, 0, 0, 0, 0, 0, 10, 10);
        check("rs_over", game_over, 0);
        idle(20, 15); check("rs_head", snake_type, 1); check("rs_score", score, 0);
        tick(0, 0); idle(21, 15); check("rs_play", snake_type, 1);

        // Self collision with length 5
        do_reset(); go();
        tick(21, 15); tick(22, 15); check("sc_len5", length, 5);
        setdir(3); tick(0, 0); setdir(1); tick(0, 0); setdir(0); tick(0, 0);
        check("sc_dead", game_over, 1);

        // Same path with length 4: tail vacates
        do_reset(); go();
        tick(21, 15); tick(0, 0); check("tv_len4", length, 4);
        setdir(3); tick(0, 0); setdir(1); tick(0, 0); setdir(0); tick(0, 0);
        check("tv_alive", game_over, 0);
        idle(21, 15); check("tv_head", snake_type, 1);

        // Random play
        for (int n = 0; n < 5000; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                ax = mx[0] + int'(mdir == 2) - int'(mdir == 1);
                ay = my[0] + int'(mdir == 3) - int'(mdir == 0);
            end else begin
                ax = $urandom_range(1, 38); ay = $urandom_range(1, 28);
            end
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, mx.size() - 1);
                qx = mx[k]; qy = my[k];
            end else begin
                qx = $urandom_range(0, 39); qy = $urandom_range(0, 29);
            end
            step(int'($urandom_range(0, 599) != 0), int'($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 2) == 0), int'($urandom_range(0, 3) == 0),
                 $urandom_range(0, 3), ax, ay, qx, qy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
Game sequencer for the snake display path. It holds the snake body as a segment shift register on the 40x30 grid of 16x16 cells. It advances the snake one cell per move tick and detects wall, self and apple hits. It answers per-cell type queries from the VGA pixel engine with the 2-bit cell code NONE/HEAD/BODY/WALL. Sits between the input/timer logic and the VGA display block.

Parameters:
MAX_LEN, 16, maximum segment count; segment storage depth.
START_X, 20, initial head cell column.
START_Y, 15, initial head cell row.
GRID_W, 40, grid width in cells; wall columns are 0 and GRID_W-1.
GRID_H, 30, grid height in cells; wall rows are 0 and GRID_H-1.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-low reset.
start  in  1  start/restart request, level sampled each clk.
move_tick  in  1  one-clk pulse: advance snake one cell.
dir_valid  in  1  qualifies dir_in.
dir_in  in  2  requested direction: UP=00, LEFT=01, RIGHT=10, DOWN=11 (opposite = bitwise invert).
apple_x  in  6  apple cell column.
apple_y  in  5  apple cell row.
query_x  in  6  cell column to classify (pixel x[9:4]).
query_y  in  5  cell row to classify (pixel y[9:4]).
snake_type  out  2  classification of query cell: NONE 00, HEAD 01, BODY 10, WALL 11.
apple_eaten  out  1  one-clk pulse when head enters apple cell.
game_over  out  1  high while in DEAD.
length  out  5  current segment count, 3..MAX_LEN.
score  out  8  apples eaten, saturating at 255.

Behaviour:
- Reset (reset==0 at posedge clk) or restart loads the initial snake:
  - state=IDLE; seg0=(START_X,START_Y), seg1=(START_X-1,START_Y), seg2=(START_X-2,START_Y); length=3.
  - dir=moved_dir=RIGHT; snake_type=00, apple_eaten=0, game_over=0, score=0.
  - Reset mid-game has the same effect.
- States:
  - IDLE: start -> PLAY.
  - PLAY: moves on move_tick; collision -> DEAD.
  - DEAD: game_over=1; start -> reload initial snake (score 0) and go to PLAY in the same edge.
  - start is ignored in PLAY. move_tick is ignored in IDLE and DEAD; the snake stays frozen and displayed.
- Direction:
  - dir_valid accepted in any state when dir_in != ~moved_dir; reversals are dropped silently.
  - dir_valid coincident with move_tick: the move uses the pre-edge dir, and the reversal check uses that dir (it becomes moved_dir). The accepted dir_in applies to the next move.
- Move (PLAY, move_tick==1):
  - next head = seg0 +/-1 in x or y per dir; UP decrements y.
  - Wall hit: next head x==0, x==GRID_W-1, y==0 or y==GRID_H-1.
  - Self hit: next head equals any seg[i] for i in 1..length-2. The tail vacates, so it is excluded. seg0 cannot be hit because reversals are blocked.
  - On hit: state=DEAD at the same edge; segments, length and score unchanged; no apple_eaten.
  - Otherwise: seg[i]<=seg[i-1] for i=1..MAX_LEN-1, seg0<=next head, moved_dir<=dir.
  - If next head==(apple_x,apple_y): apple_eaten=1 for exactly that one cycle; length+1 saturating at MAX_LEN; score+1 saturating at 255. At MAX_LEN the pulse and score still occur.
- Query path, 1-clk latency:
  - snake_type registered from the query_x/query_y sampled at the previous edge.
  - Priority: WALL > HEAD (seg0) > BODY (seg1..length-1) > NONE.
  - Segments at index >= length are ignored.
  - Query runs in every state except during reset.
  - Query coincident with a move reflects pre-move segments.
- Widths: coordinates are 6-bit x and 5-bit y; no wrap-around is possible because the wall check precedes every update.

Test Plan:
- Reset, query (20,15)/(19,15)/(17,15)/(0,5) -> snake_type 01/10/00/11 one clk later; length=3, score=0, game_over=0.
- start, then 3 move_ticks with no dir -> head (23,15), body (22,15),(21,15); query (20,15) -> 00.
- Apple at (21,15), start, 1 move_tick -> apple_eaten high one clk, length=4, score=1; tail (18,15) retained.
- Head at (20,15) moving RIGHT, dir_valid dir_in=LEFT (01) -> ignored. Next move -> head (21,15). dir_valid UP plus move_tick in same clk -> move to (22,15); following tick -> (22,14).
- Move UP from row 1 -> game_over=1, segments frozen, further move_ticks ignored. start -> snake reloaded at (20,15), score=0, state PLAY.
- Length 5, path RIGHT,DOWN,LEFT,UP into own body -> DEAD. Same path with length 4 (tail vacates) -> no collision.
